// File: rtl/cache_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the cache sequencing controller.
package cache_ctrl_pkg;

   localparam int unsigned WAYS      = 4;
   localparam int unsigned BANKS     = 16;
   localparam int unsigned LINE_BITS = 512;
   localparam int unsigned WAY_W     = 2;
   localparam int unsigned BANK_W    = 4;
   localparam int unsigned OFFSET_W  = 6;
   localparam int unsigned WEN_W     = BANKS * WAYS;
   localparam int unsigned STATE_W   = 3;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOOKUP   = 3'd1;
   localparam logic [STATE_W-1:0] ST_WB       = 3'd2;
   localparam logic [STATE_W-1:0] ST_FILL_REQ = 3'd3;
   localparam logic [STATE_W-1:0] ST_FILL     = 3'd4;
   localparam logic [STATE_W-1:0] ST_RESP     = 3'd5;

   typedef enum logic [STATE_W-1:0] {
      IDLE     = ST_IDLE,
      LOOKUP   = ST_LOOKUP,
      WB       = ST_WB,
      FILL_REQ = ST_FILL_REQ,
      FILL     = ST_FILL,
      RESP     = ST_RESP
   } ctrlState_t;

   function automatic logic [WAY_W-1:0] onehot2bin4(input logic [WAYS-1:0] oneHot);
      if (oneHot[3])      return 2'd3;
      else if (oneHot[2]) return 2'd2;
      else if (oneHot[1]) return 2'd1;
      else                return 2'd0;
   endfunction

endpackage

// File: rtl/cache_ctrl_fsm_plru.sv
// Per-set 3-bit tree-PLRU state: victim lookup for one set, touch update for another.
module cache_plru_tree
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned indexWidth = 8,
   parameter int unsigned NoOfSets   = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [indexWidth-1:0] lookupIndex,
   output logic [WAY_W-1:0]      victimWay_c,
   input  logic                  touchEn,
   input  logic [indexWidth-1:0] touchIndex,
   input  logic [WAY_W-1:0]      touchWay
);

   logic [2:0] plruBits [NoOfSets];
   logic [2:0] lookBits;
   logic [2:0] curBits;
   logic [2:0] newBits;

   // Bit order {b2,b1,b0}: b0 picks the pair, b1/b2 pick within {0,1}/{2,3}.
   always_comb begin
      lookBits    = plruBits[lookupIndex];
      victimWay_c = lookBits[0] ? {1'b1, lookBits[2]} : {1'b0, lookBits[1]};
   end

   // Touch points every bit on the path away from the accessed way.
   always_comb begin
      curBits = plruBits[touchIndex];
      newBits = curBits;
      case (touchWay)
         2'd0:    newBits = {curBits[2], 1'b1, 1'b1};
         2'd1:    newBits = {curBits[2], 1'b0, 1'b1};
         2'd2:    newBits = {1'b1, curBits[1], 1'b0};
         default: newBits = {1'b0, curBits[1], 1'b0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < NoOfSets; s++) plruBits[s] <= '0;
      end else if (touchEn) begin
         plruBits[touchIndex] <= newBits;
      end
   end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for the 4-way set-associative cache: lookup, victim write-back,
// line refill and access completion, plus per-set dirty bits.
module cache_ctrl_fsm
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned tagSize    = 18,
   parameter int unsigned indexWidth = 8,
   parameter int unsigned NoOfSets   = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpuReq,
   input  logic                  cpuWe,
   input  logic [indexWidth-1:0] cpuIndex,
   input  logic [OFFSET_W-1:0]   cpuOffset,
   input  logic [WAYS-1:0]       hitWay,
   input  logic [WAYS-1:0]       validWay,
   input  logic                  memAck,
   output logic                  cpuReady,
   output logic                  memReq,
   output logic                  memWe,
   output logic                  memUseVictimTag,
   output logic [WEN_W-1:0]      wEnData,
   output logic [WAYS-1:0]       wEnMainMemWen,
   output logic                  readMiss,
   output logic [WAY_W-1:0]      waySelect,
   output logic                  hit
);

   if (NoOfSets != (1 << indexWidth) || tagSize == 0) begin : gBadParams
      $error("cache_ctrl_fsm: NoOfSets must equal 2**indexWidth and tagSize must be nonzero");
   end

   ctrlState_t state, stateNext;

   logic                  reqWe;
   logic [indexWidth-1:0] reqIndex;
   logic [BANK_W-1:0]     reqBank;
   logic [WAY_W-1:0]      way, wayNext;
   logic [WAYS-1:0]       dirty [NoOfSets];
   logic                  dirtySet, dirtyClr, touchEn;
   logic [WAY_W-1:0]      plruVictim_c, victimSel;
   logic                  unusedByteBits;

   logic                  cpuReadyNext, memReqNext, memWeNext, memUseVictimTagNext;
   logic                  readMissNext, hitNext;
   logic [WEN_W-1:0]      wEnDataNext;
   logic [WAYS-1:0]       wEnMainMemWenNext;
   logic [WAY_W-1:0]      waySelectNext;

   assign unusedByteBits = ^cpuOffset[1:0];

   cache_plru_tree #(
      .indexWidth (indexWidth),
      .NoOfSets   (NoOfSets)
   ) uPlru (
      .clk         (clk),
      .reset       (reset),
      .lookupIndex (reqIndex),
      .victimWay_c (plruVictim_c),
      .touchEn     (touchEn),
      .touchIndex  (reqIndex),
      .touchWay    (way)
   );

   // Empty ways are filled lowest-first; PLRU only chooses once the set is full.
   always_comb begin
      if (!validWay[0])      victimSel = 2'd0;
      else if (!validWay[1]) victimSel = 2'd1;
      else if (!validWay[2]) victimSel = 2'd2;
      else if (!validWay[3]) victimSel = 2'd3;
      else                   victimSel = plruVictim_c;
   end

   always_comb begin
      stateNext = state;
      wayNext   = way;
      dirtySet  = 1'b0;
      dirtyClr  = 1'b0;
      touchEn   = 1'b0;
      case (state)
         IDLE:     if (cpuReq) stateNext = LOOKUP;
         LOOKUP: begin
            if (|hitWay) begin
               wayNext   = onehot2bin4(hitWay);
               stateNext = RESP;
            end else begin
               wayNext   = victimSel;
               stateNext = (validWay[victimSel] && dirty[reqIndex][victimSel]) ? WB : FILL_REQ;
            end
         end
         WB: if (memAck) begin
            dirtyClr  = 1'b1;
            stateNext = FILL_REQ;
         end
         FILL_REQ: if (memAck) stateNext = FILL;
         FILL:     stateNext = RESP;
         RESP: begin
            touchEn   = 1'b1;
            dirtySet  = reqWe;
            stateNext = IDLE;
         end
         default:  stateNext = IDLE;
      endcase

      // Outputs are decoded from the upcoming state so they register in step with it.
      cpuReadyNext        = (stateNext == RESP);
      hitNext             = (stateNext == RESP);
      memReqNext          = (stateNext == WB) || (stateNext == FILL_REQ);
      memWeNext           = (stateNext == WB);
      memUseVictimTagNext = (stateNext == WB);
      readMissNext        = (stateNext == FILL_REQ) || (stateNext == FILL);
      wEnMainMemWenNext   = (stateNext == FILL) ? (WAYS'(1) << wayNext) : '0;
      wEnDataNext         = (stateNext == RESP && reqWe) ? (WEN_W'(1) << {reqBank, wayNext}) : '0;
      waySelectNext       = (stateNext == IDLE || stateNext == LOOKUP) ? '0 : wayNext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         way             <= '0;
         reqWe           <= 1'b0;
         reqIndex        <= '0;
         reqBank         <= '0;
         cpuReady        <= 1'b0;
         memReq          <= 1'b0;
         memWe           <= 1'b0;
         memUseVictimTag <= 1'b0;
         wEnData         <= '0;
         wEnMainMemWen   <= '0;
         readMiss        <= 1'b0;
         waySelect       <= '0;
         hit             <= 1'b0;
         for (int s = 0; s < NoOfSets; s++) dirty[s] <= '0;
      end else begin
         state           <= stateNext;
         way             <= wayNext;
         cpuReady        <= cpuReadyNext;
         memReq          <= memReqNext;
         memWe           <= memWeNext;
         memUseVictimTag <= memUseVictimTagNext;
         wEnData         <= wEnDataNext;
         wEnMainMemWen   <= wEnMainMemWenNext;
         readMiss        <= readMissNext;
         waySelect       <= waySelectNext;
         hit             <= hitNext;
         if (state == IDLE && cpuReq) begin
            reqWe    <= cpuWe;
            reqIndex <= cpuIndex;
            reqBank  <= cpuOffset[5:2];
         end
         // Write-back clear and write-set live in different states, never the same cycle.
         if (dirtyClr) dirty[reqIndex][way] <= 1'b0;
         if (dirtySet) dirty[reqIndex][way] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed self-checking bench for cache_ctrl_fsm: hits, clean/dirty misses, PLRU order,
// reset mid write-back and stray memAck.
module tb_cache_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpuReq, cpuWe;
   logic [7:0]  cpuIndex;
   logic [5:0]  cpuOffset;
   logic [3:0]  hitWay, validWay;
   logic        memAck;
   logic        cpuReady, memReq, memWe, memUseVictimTag, readMiss, hit;
   logic [63:0] wEnData;
   logic [3:0]  wEnMainMemWen;
   logic [1:0]  waySelect;

   int nVec = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   cache_ctrl_fsm #(.tagSize(18), .indexWidth(8), .NoOfSets(256)) dut (
      .clk             (clk),
      .reset           (reset),
      .cpuReq          (cpuReq),
      .cpuWe           (cpuWe),
      .cpuIndex        (cpuIndex),
      .cpuOffset       (cpuOffset),
      .hitWay          (hitWay),
      .validWay        (validWay),
      .memAck          (memAck),
      .cpuReady        (cpuReady),
      .memReq          (memReq),
      .memWe           (memWe),
      .memUseVictimTag (memUseVictimTag),
      .wEnData         (wEnData),
      .wEnMainMemWen   (wEnMainMemWen),
      .readMiss        (readMiss),
      .waySelect       (waySelect),
      .hit             (hit)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] expd);
      nVec++;
      assert (obs === expd) else begin
         nErr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
      end
   endtask

   task automatic chkZero(input string tag);
      chk(tag, {cpuReady, memReq, memWe, memUseVictimTag, readMiss, hit,
                waySelect, wEnMainMemWen, wEnData}, 76'd0);
   endtask

   task automatic reqHit(input logic [7:0] idx, input logic [5:0] off, input logic we,
                         input logic [3:0] hw, input logic [1:0] expWay, input logic [63:0] expWen);
      cpuReq = 1'b1; cpuWe = we; cpuIndex = idx; cpuOffset = off;
      hitWay = hw; validWay = 4'hF;
      tick();
      chk("hit.lookup.cpuReady", cpuReady, 0);
      tick();
      chk("hit.resp.cpuReady", cpuReady, 1);
      chk("hit.resp.waySelect", waySelect, expWay);
      chk("hit.resp.hit", hit, 1);
      chk("hit.resp.memReq", memReq, 0);
      chk("hit.resp.wEnMainMemWen", wEnMainMemWen, 0);
      chk("hit.resp.wEnData", wEnData, expWen);
      cpuReq = 1'b0; hitWay = 4'h0;
      tick();
      chk("hit.idle.cpuReady", cpuReady, 0);
      chk("hit.idle.wEnData", wEnData, 0);
   endtask

   task automatic reqMiss(input logic [7:0] idx, input logic [5:0] off, input logic we,
                          input logic [3:0] vw, input bit expWb, input logic [1:0] expWay,
                          input logic [63:0] expWen);
      cpuReq = 1'b1; cpuWe = we; cpuIndex = idx; cpuOffset = off;
      hitWay = 4'h0; validWay = vw;
      tick();
      chk("miss.lookup.memReq", memReq, 0);
      tick();
      if (expWb) begin
         chk("miss.wb.memReq", memReq, 1);
         chk("miss.wb.memWe", memWe, 1);
         chk("miss.wb.victimTag", memUseVictimTag, 1);
         chk("miss.wb.waySelect", waySelect, expWay);
         tick();
         chk("miss.wb.hold", memReq, 1);
         memAck = 1'b1;
         tick();
         memAck = 1'b0;
      end
      chk("miss.fillreq.memReq", memReq, 1);
      chk("miss.fillreq.memWe", memWe, 0);
      chk("miss.fillreq.victimTag", memUseVictimTag, 0);
      chk("miss.fillreq.readMiss", readMiss, 1);
      tick();
      chk("miss.fillreq.hold", memReq, 1);
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      chk("miss.fill.wEnMainMemWen", wEnMainMemWen, 4'(1) << expWay);
      chk("miss.fill.readMiss", readMiss, 1);
      chk("miss.fill.memReq", memReq, 0);
      tick();
      chk("miss.resp.cpuReady", cpuReady, 1);
      chk("miss.resp.wEnMainMemWen", wEnMainMemWen, 0);
      chk("miss.resp.hit", hit, 1);
      chk("miss.resp.waySelect", waySelect, expWay);
      chk("miss.resp.wEnData", wEnData, expWen);
      cpuReq = 1'b0;
      tick();
      chk("miss.idle.cpuReady", cpuReady, 0);
   endtask

   initial begin
      reset = 1'b1; cpuReq = 1'b0; cpuWe = 1'b0; cpuIndex = '0; cpuOffset = '0;
      hitWay = '0; validWay = '0; memAck = 1'b0;
      tick();
      tick();
      chkZero("reset.outputs");
      reset = 1'b0;
      tick();
      chkZero("idle.outputs");

      // Cold read miss in set 5 fills way0.
      reqMiss(8'd5, 6'h00, 1'b0, 4'b0000, 1'b0, 2'd0, 64'd0);

      // Read hit on way2.
      reqHit(8'd5, 6'h00, 1'b0, 4'b0100, 2'd2, 64'd0);

      // Write hit way1 at bank 9, then steer PLRU to way1 and evict it dirty.
      reqHit(8'd3, 6'h24, 1'b1, 4'b0010, 2'd1, 64'd1 << 37);
      reqHit(8'd3, 6'h00, 1'b0, 4'b0001, 2'd0, 64'd0);
      reqHit(8'd3, 6'h00, 1'b0, 4'b0100, 2'd2, 64'd0);
      reqMiss(8'd3, 6'h00, 1'b0, 4'hF, 1'b1, 2'd1, 64'd0);

      // Fill set 9 in way order, then PLRU victims way0 and (after touching 0) way2.
      reqMiss(8'd9, 6'h00, 1'b0, 4'b0000, 1'b0, 2'd0, 64'd0);
      reqMiss(8'd9, 6'h00, 1'b0, 4'b0001, 1'b0, 2'd1, 64'd0);
      reqMiss(8'd9, 6'h00, 1'b0, 4'b0011, 1'b0, 2'd2, 64'd0);
      reqMiss(8'd9, 6'h00, 1'b0, 4'b0111, 1'b0, 2'd3, 64'd0);
      reqMiss(8'd9, 6'h00, 1'b0, 4'b1111, 1'b0, 2'd0, 64'd0);
      reqMiss(8'd9, 6'h00, 1'b0, 4'b1111, 1'b0, 2'd2, 64'd0);

      // Write-allocate: write miss strobes bank 15 of the filled way.
      reqMiss(8'd20, 6'h3C, 1'b1, 4'b0000, 1'b0, 2'd0, 64'd1 << 60);

      // Dirty way1 again, reach WB, then reset mid-transfer.
      reqHit(8'd3, 6'h24, 1'b1, 4'b0010, 2'd1, 64'd1 << 37);
      reqHit(8'd3, 6'h00, 1'b0, 4'b0001, 2'd0, 64'd0);
      reqHit(8'd3, 6'h00, 1'b0, 4'b0100, 2'd2, 64'd0);
      cpuReq = 1'b1; cpuWe = 1'b0; cpuIndex = 8'd3; cpuOffset = 6'h00;
      hitWay = 4'h0; validWay = 4'hF;
      tick();
      tick();
      chk("rstwb.memReq", memReq, 1);
      chk("rstwb.memWe", memWe, 1);
      cpuReq = 1'b0; reset = 1'b1; memAck = 1'b1;
      tick();
      reset = 1'b0; memAck = 1'b0;
      chkZero("rstwb.outputs");
      tick();
      chkZero("rstwb.idle");
      // Same PLRU path to way1; dirty was cleared so no write-back.
      reqHit(8'd3, 6'h00, 1'b0, 4'b0001, 2'd0, 64'd0);
      reqHit(8'd3, 6'h00, 1'b0, 4'b0100, 2'd2, 64'd0);
      reqMiss(8'd3, 6'h00, 1'b0, 4'hF, 1'b0, 2'd1, 64'd0);

      // Stray memAck in IDLE and LOOKUP is ignored.
      memAck = 1'b1;
      tick();
      tick();
      chkZero("strayack.idle");
      reqHit(8'd5, 6'h00, 1'b0, 4'b0100, 2'd2, 64'd0);
      memAck = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
